// File: rtl/multicycle_ctrl.sv
// Purpose : multi-cycle MIPS control FSM driving datapath muxes/enables, flags illegal opcodes, counts fetches.
// Latency : lw 5 cycles, sw/R/addi 4, beq/bne/j 3 with zero memory wait; outputs are decoded from state.
// Backpressure: FETCH, MEM_RD and MEM_WR hold, with their request asserted, until mem_ready (when MEM_HANDSHAKE=1).
module multicycle_ctrl #(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit SUPPORT_BNE   = 1'b1,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op_code,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_beq,
    output logic             pc_write_bne,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEM_ADR = 4'd2,
        S_MEM_RD  = 4'd3,
        S_MEM_WB  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_R_EXEC  = 4'd6,
        S_R_WB    = 4'd7,
        S_BEQ     = 4'd8,
        S_JUMP    = 4'd9,
        S_BNE     = 4'd10,
        S_I_EXEC  = 4'd11,
        S_I_WB    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t           r_state;
    state_t           w_next;
    logic [5:0]       r_op;
    logic             r_illegal;
    logic             w_illegal;
    logic             w_done;
    logic [CNT_W-1:0] r_count;

    // Without the handshake every memory access is treated as single-cycle.
    assign w_done      = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign state       = r_state;
    assign illegal_op  = r_illegal;
    assign instr_count = r_count;

    // State register; reset lands in FETCH immediately so no later partial write can occur.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    // Opcode captured in DECODE so MEM_ADR can choose lw/sw after the IR input moves on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                   r_op <= 6'd0;
        else if (r_state == S_DECODE) r_op <= op_code;
    end

    // Illegal pulse lives for exactly the cycle after the offending DECODE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_illegal <= 1'b0;
        else       r_illegal <= w_illegal;
    end

    // Retired-instruction counter: one tick per completed fetch, wrapping naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                            r_count <= '0;
        else if (r_state == S_FETCH && w_done) r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // Next-state selection and state-decoded datapath controls.
    always_comb begin
        w_next       = S_FETCH;
        w_illegal    = 1'b0;
        pc_write     = 1'b0;
        pc_write_beq = 1'b0;
        pc_write_bne = 1'b0;
        i_or_d       = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        mem_to_reg   = 1'b0;
        reg_dst      = 1'b0;
        reg_write    = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'b00;
        alu_op       = 2'b00;
        pc_source    = 2'b00;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = w_done;
                pc_write  = w_done;
                w_next    = w_done ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (op_code)
                    OP_RTYPE:     w_next = S_R_EXEC;
                    OP_LW, OP_SW: w_next = S_MEM_ADR;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_I_EXEC;
                    OP_BNE: begin
                        if (SUPPORT_BNE) w_next = S_BNE;
                        else             w_illegal = 1'b1;
                    end
                    default:      w_illegal = 1'b1;
                endcase
            end
            S_MEM_ADR, S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (r_state == S_I_EXEC) w_next = S_I_WB;
                else                     w_next = (r_op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                w_next   = w_done ? S_MEM_WB : S_MEM_RD;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                w_next    = w_done ? S_FETCH : S_MEM_WR;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                w_next    = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_I_WB: begin
                reg_write = 1'b1;
            end
            S_BEQ, S_BNE: begin
                alu_src_a    = 1'b1;
                alu_op       = 2'b01;
                pc_source    = 2'b01;
                pc_write_beq = (r_state == S_BEQ);
                pc_write_bne = (r_state == S_BNE);
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            default: w_next = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a default-parameter instance and a CNT_W=4, no-bne, no-handshake instance.
// Expected per-cycle state/controls/pulse/count are queued as each instruction is scheduled, then popped and compared.
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, rst2;
    logic [5:0] op1, op2;
    logic       rdy1, rdy2;

    logic pcw1, beq1, bne1, iod1, mr1, mw1, irw1, m2r1, rd1, rw1, asa1, ill1;
    logic [1:0] asb1, aop1, pcs1;
    logic [3:0] st1;
    logic [31:0] cnt1;
    logic pcw2, beq2, bne2, iod2, mr2, mw2, irw2, m2r2, rd2, rw2, asa2, ill2;
    logic [1:0] asb2, aop2, pcs2;
    logic [3:0] st2;
    logic [3:0] cnt2;

    wire [16:0] outs1 = {pcw1, beq1, bne1, iod1, mr1, mw1, irw1, m2r1, rd1, rw1, asa1, asb1, aop1, pcs1};
    wire [16:0] outs2 = {pcw2, beq2, bne2, iod2, mr2, mw2, irw2, m2r2, rd2, rw2, asa2, asb2, aop2, pcs2};

    multicycle_ctrl dut1 (
        .clk(clk), .reset(reset), .op_code(op1), .mem_ready(rdy1),
        .pc_write(pcw1), .pc_write_beq(beq1), .pc_write_bne(bne1), .i_or_d(iod1),
        .mem_read(mr1), .mem_write(mw1), .ir_write(irw1), .mem_to_reg(m2r1),
        .reg_dst(rd1), .reg_write(rw1), .alu_src_a(asa1), .alu_src_b(asb1),
        .alu_op(aop1), .pc_source(pcs1), .state(st1), .illegal_op(ill1), .instr_count(cnt1)
    );

    multicycle_ctrl #(.MEM_HANDSHAKE(1'b0), .SUPPORT_BNE(1'b0), .CNT_W(4)) dut2 (
        .clk(clk), .reset(rst2), .op_code(op2), .mem_ready(rdy2),
        .pc_write(pcw2), .pc_write_beq(beq2), .pc_write_bne(bne2), .i_or_d(iod2),
        .mem_read(mr2), .mem_write(mw2), .ir_write(irw2), .mem_to_reg(m2r2),
        .reg_dst(rd2), .reg_write(rw2), .alu_src_a(asa2), .alu_src_b(asb2),
        .alu_op(aop2), .pc_source(pcs2), .state(st2), .illegal_op(ill2), .instr_count(cnt2)
    );

    typedef struct packed {
        logic        sel;
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [16:0] outs;
        logic        ill;
        logic [31:0] cnt;
    } exp_t;

    exp_t       q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [1:0] pend_ill = 2'b00;
    int         exp_cnt[2] = '{0, 0};

    // Control vector expected in each state, bit order matching outs1/outs2.
    function automatic logic [16:0] ctl(input logic [3:0] st, input logic d);
        logic pw, pb, pn, io, mr, mw, iw, mtr, rdst, rw, sa;
        logic [1:0] sb, ao, ps;
        {pw, pb, pn, io, mr, mw, iw, mtr, rdst, rw, sa} = 11'd0;
        sb = 2'b00; ao = 2'b00; ps = 2'b00;
        case (st)
            4'd0:  begin mr = 1'b1; sb = 2'b01; iw = d; pw = d; end
            4'd1:  sb = 2'b11;
            4'd2, 4'd11: begin sa = 1'b1; sb = 2'b10; end
            4'd3:  begin mr = 1'b1; io = 1'b1; end
            4'd4:  begin rw = 1'b1; mtr = 1'b1; end
            4'd5:  begin mw = 1'b1; io = 1'b1; end
            4'd6:  begin sa = 1'b1; ao = 2'b10; end
            4'd7:  begin rw = 1'b1; rdst = 1'b1; end
            4'd8:  begin sa = 1'b1; ao = 2'b01; ps = 2'b01; pb = 1'b1; end
            4'd10: begin sa = 1'b1; ao = 2'b01; ps = 2'b01; pn = 1'b1; end
            4'd9:  begin pw = 1'b1; ps = 2'b10; end
            4'd12: rw = 1'b1;
            default: ;
        endcase
        return {pw, pb, pn, io, mr, mw, iw, mtr, rdst, rw, sa, sb, ao, ps};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Queue one expected cycle; dut2 ignores mem_ready, so it is driven low there.
    task automatic push(input logic s, input logic [5:0] op, input logic rdy, input logic [3:0] st);
        exp_t e;
        logic d;
        d      = s ? 1'b1 : rdy;
        e.sel  = s;
        e.op   = op;
        e.rdy  = s ? 1'b0 : rdy;
        e.st   = st;
        e.outs = ctl(st, d);
        e.ill  = pend_ill[s];
        pend_ill[s] = 1'b0;
        e.cnt  = s ? (exp_cnt[s] & 32'hF) : exp_cnt[s];
        if (st == 4'd0 && d) exp_cnt[s]++;
        q.push_back(e);
    endtask

    // Schedule a whole instruction; after DECODE the opcode input is scrambled to prove the latch is used.
    task automatic do_instr(input logic s, input logic [5:0] op, input int ws, input int fws);
        logic [5:0] jk;
        jk = 6'h3F;
        for (int k = 0; k < fws; k++) push(s, op, 1'b0, 4'd0);
        push(s, op, 1'b1, 4'd0);
        push(s, op, 1'b1, 4'd1);
        case (op)
            6'b000000: begin push(s, jk, 1'b1, 4'd6); push(s, jk, 1'b1, 4'd7); end
            6'b100011: begin
                push(s, jk, 1'b1, 4'd2);
                for (int k = 0; k < ws; k++) push(s, jk, 1'b0, 4'd3);
                push(s, jk, 1'b1, 4'd3);
                push(s, jk, 1'b1, 4'd4);
            end
            6'b101011: begin
                push(s, jk, 1'b1, 4'd2);
                for (int k = 0; k < ws; k++) push(s, jk, 1'b0, 4'd5);
                push(s, jk, 1'b1, 4'd5);
            end
            6'b000100: push(s, jk, 1'b1, 4'd8);
            6'b000101: if (!s) push(s, jk, 1'b1, 4'd10); else pend_ill[s] = 1'b1;
            6'b000010: push(s, jk, 1'b1, 4'd9);
            6'b001000: begin push(s, jk, 1'b1, 4'd11); push(s, jk, 1'b1, 4'd12); end
            default:   pend_ill[s] = 1'b1;
        endcase
    endtask

    // Drain the scoreboard: drive each cycle's inputs, let them settle, compare, advance a clock.
    task automatic run();
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            if (!e.sel) begin op1 = e.op; rdy1 = e.rdy; end
            else        begin op2 = e.op; rdy2 = e.rdy; end
            #1;
            if (!e.sel) begin
                chk("state", {28'd0, st1}, {28'd0, e.st});
                chk("ctrl", {15'd0, outs1}, {15'd0, e.outs});
                chk("illegal", {31'd0, ill1}, {31'd0, e.ill});
                chk("count", cnt1, e.cnt);
            end else begin
                chk("state2", {28'd0, st2}, {28'd0, e.st});
                chk("ctrl2", {15'd0, outs2}, {15'd0, e.outs});
                chk("illegal2", {31'd0, ill2}, {31'd0, e.ill});
                chk("count2", {28'd0, cnt2}, e.cnt);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout compared=%0d mismatched=%0d", n_cmp, n_err);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; rst2 = 1'b1;
        op1 = 6'd0; op2 = 6'd0; rdy1 = 1'b0; rdy2 = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_state", {28'd0, st1}, 32'd0);
        chk("rst_count", cnt1, 32'd0);
        chk("rst_illegal", {31'd0, ill1}, 32'd0);
        chk("rst_ctrl", {15'd0, outs1}, {15'd0, ctl(4'd0, 1'b0)});
        @(negedge clk);
        reset = 1'b0;

        do_instr(1'b0, 6'b000000, 0, 0); run();   // R-type
        do_instr(1'b0, 6'b100011, 3, 0); run();   // lw, 3-cycle read stall
        do_instr(1'b0, 6'b101011, 2, 1); run();   // sw, fetch and write stalls
        do_instr(1'b0, 6'b000100, 0, 0); run();   // beq
        do_instr(1'b0, 6'b000101, 0, 0); run();   // bne
        do_instr(1'b0, 6'b000010, 0, 0); run();   // j
        do_instr(1'b0, 6'b001000, 0, 0); run();   // addi
        do_instr(1'b0, 6'b111111, 0, 0);          // illegal
        do_instr(1'b0, 6'b000000, 0, 0); run();   // next fetch carries the pulse

        // Reset while MEM_WR is stalled
        push(1'b0, 6'b101011, 1'b1, 4'd0);
        push(1'b0, 6'b101011, 1'b1, 4'd1);
        push(1'b0, 6'h3F, 1'b1, 4'd2);
        push(1'b0, 6'h3F, 1'b0, 4'd5);
        push(1'b0, 6'h3F, 1'b0, 4'd5);
        run();
        rdy1 = 1'b0;
        reset = 1'b1;
        #1;
        chk("midrst_state", {28'd0, st1}, 32'd0);
        chk("midrst_mem_write", {31'd0, mw1}, 32'd0);
        chk("midrst_count", cnt1, 32'd0);
        exp_cnt[0] = 0;
        pend_ill[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        do_instr(1'b0, 6'b100011, 0, 0); run();

        // Narrow counter, bne illegal, handshake ignored
        rst2 = 1'b0;
        do_instr(1'b1, 6'b000101, 0, 0);
        for (int k = 0; k < 16; k++) do_instr(1'b1, 6'b000010, 0, 0);
        run();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
